// File: rtl/csa_accumulator.sv
// Multi-operand accumulator: carry-save accumulation per beat, then a chunked
// ripple resolve of the redundant (S, C) pair before presenting the result.
module csa_accumulator #(
    parameter int WIDTH = 4,
    parameter int GUARD = 4,
    parameter int CHUNK = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH+GUARD-1:0]   out_sum,
    output logic [GUARD:0]           out_count,
    output logic                     out_ovf
);

    localparam int ACC_W = WIDTH + GUARD;
    localparam int NCH   = ACC_W / CHUNK;
    localparam int CNT_W = GUARD + 1;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(2 ** GUARD);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(2 ** GUARD + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCH - 1);

    typedef enum logic [1:0] {ACCUM, RESOLVE, DONE} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   s_q, s_d, c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               cin_q, cin_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   ocnt_q, ocnt_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W-1:0]   din;
    logic [CHUNK:0]     chunk_add;
    int                 base;

    assign din       = {{GUARD{1'b0}}, in_data};
    assign in_ready  = (state_q == ACCUM) && !rst;
    assign out_valid = (state_q == DONE);
    assign out_sum   = sum_q;
    assign out_count = ocnt_q;
    assign out_ovf   = ovf_q;

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        cin_d     = cin_q;
        sum_d     = sum_q;
        ocnt_d    = ocnt_q;
        ovf_d     = ovf_q;
        base      = int'(idx_q) * CHUNK;
        chunk_add = '0;

        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    // 3:2 compression; carry-out of the top bit falls off the shift
                    s_d = s_q ^ c_q ^ din;
                    c_d = ((s_q & c_q) | (s_q & din) | (c_q & din)) << 1;
                    if (cnt_q != CNT_SAT)
                        cnt_d = cnt_q + CNT_W'(1);
                    if (in_last) begin
                        state_d = RESOLVE;
                        idx_d   = '0;
                        cin_d   = 1'b0;
                    end
                end
            end
            RESOLVE: begin
                chunk_add = {1'b0, s_q[base +: CHUNK]} + {1'b0, c_q[base +: CHUNK]}
                          + {{CHUNK{1'b0}}, cin_q};
                sum_d[base +: CHUNK] = chunk_add[CHUNK-1:0];
                cin_d = chunk_add[CHUNK];
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                    ocnt_d  = cnt_q;
                    ovf_d   = (cnt_q > CNT_FULL);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = ACCUM;
                    s_d     = '0;
                    c_d     = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            s_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            cin_q   <= 1'b0;
            sum_q   <= '0;
            ocnt_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            cin_q   <= cin_d;
            sum_q   <= sum_d;
            ocnt_q  <= ocnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
